hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core; sequences fetch/decode/execute registers around decoded instruction classes.
- Generates stall, flush, PC-redirect and forwarding selects from decode/execute/memory/writeback stage fields.
- Sits beside the decode stage and consumes the instruction type produced by the control unit.
- Owns multi-cycle flush penalty and memory-wait sequencing.

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/hazard_ctrl_fwd_unit.sv | 42 ++++
 rtl/hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared control typedefs for the RV32I pipeline hazard controller.
//   HazardState : controller FSM states (RUN, MEM_WAIT, FLUSH)
//   FWD_*       : execute-operand forwarding select encodings
//   fwd_select  : forwarding priority helper (memory beats writeback, x0 never)
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } HazardState;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Forward select from pre-computed per-stage match flags; the match flags
    // already include the write-enable and the x0 exclusion.
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_fwd_unit
// Purely combinational operand forwarding for the execute stage.
// Ports:
//   i_rs1_e, i_rs2_e          execute-stage source registers
//   i_rd_m, i_reg_write_m     memory-stage destination / write enable
//   i_rd_w, i_reg_write_w     writeback-stage destination / write enable
//   o_fwd_a, o_fwd_b          operand A/B source select (FWD_REG/WB/MEM)
// -----------------------------------------------------------------------------
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs1_e,
    input  logic [REG_ADDR_W-1:0] i_rs2_e,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_reg_write_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_w,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b
);

    logic w_m_valid;
    logic w_w_valid;

    // A stage can only forward when it writes a real register (never x0).
    assign w_m_valid = i_reg_write_m && (i_rd_m != {REG_ADDR_W{1'b0}});
    assign w_w_valid = i_reg_write_w && (i_rd_w != {REG_ADDR_W{1'b0}});

    // Operand source selection with memory-stage priority.
    always_comb begin
        o_fwd_a = FWD_REG;
        o_fwd_b = FWD_REG;
        o_fwd_a = fwd_select(w_m_valid && (i_rd_m == i_rs1_e),
                             w_w_valid && (i_rd_w == i_rs1_e));
        o_fwd_b = fwd_select(w_m_valid && (i_rd_m == i_rs2_e),
                             w_w_valid && (i_rd_w == i_rs2_e));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RV32I core. Produces stall, flush,
// PC-redirect and forwarding selects, and sequences the multi-cycle redirect
// flush penalty and data-memory wait.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating performance counters
//   oStallCycles / oFlushCycles / oRedirects.
// Ports:
//   iClk, iRstN                   clock, asynchronous active-low reset
//   iRs1D/iRs2D, iUseRs1D/2D      decode-stage sources and usage
//   iRdE, iRegWriteE, iIsLoadE    execute-stage destination info
//   iRs1E, iRs2E                  execute-stage sources (forwarding)
//   iRdM, iRegWriteM              memory-stage destination
//   iRdW, iRegWriteW              writeback-stage destination
//   iRedirectE                    taken branch / jump resolved in execute
//   iMemBusy                      data memory not ready
//   oStallF/D/E/M                 hold PC / F-D / D-E / E-M registers
//   oFlushD, oFlushE              clear F-D / D-E registers
//   oPcRedirect                   select branch/jump target
//   oFwdA, oFwdB                  execute operand source selects
//   oState                        current FSM state (debug)
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_PENALTY = 2,
    parameter int REG_ADDR_W       = 5,
    parameter int PERF_W           = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic [REG_ADDR_W-1:0] iRs1D,
    input  logic [REG_ADDR_W-1:0] iRs2D,
    input  logic                  iUseRs1D,
    input  logic                  iUseRs2D,
    input  logic [REG_ADDR_W-1:0] iRdE,
    input  logic                  iRegWriteE,
    input  logic                  iIsLoadE,
    input  logic [REG_ADDR_W-1:0] iRs1E,
    input  logic [REG_ADDR_W-1:0] iRs2E,
    input  logic [REG_ADDR_W-1:0] iRdM,
    input  logic                  iRegWriteM,
    input  logic [REG_ADDR_W-1:0] iRdW,
    input  logic                  iRegWriteW,
    input  logic                  iRedirectE,
    input  logic                  iMemBusy,
    output logic                  oStallF,
    output logic                  oStallD,
    output logic                  oStallE,
    output logic                  oStallM,
    output logic                  oFlushD,
    output logic                  oFlushE,
    output logic                  oPcRedirect,
    output logic [1:0]            oFwdA,
    output logic [1:0]            oFwdB,
    output logic [1:0]            oState
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     oStallCycles,
    output logic [PERF_W-1:0]     oFlushCycles,
    output logic [PERF_W-1:0]     oRedirects
`endif
);

    // Penalty counter value loaded on a redirect; the redirect cycle itself
    // counts as the first bubble, so FLUSH covers the remaining ones.
    localparam logic [1:0] LP_CNT_RELOAD = 2'(REDIRECT_PENALTY - 1);

    HazardState r_state;
    HazardState w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       r_pend;
    logic       w_pend_nxt;

    logic       w_lu;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_stall_m;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_pc_redirect;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    hazard_ctrl_fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_unit (
        .i_rs1_e       (iRs1E),
        .i_rs2_e       (iRs2E),
        .i_rd_m        (iRdM),
        .i_reg_write_m (iRegWriteM),
        .i_rd_w        (iRdW),
        .i_reg_write_w (iRegWriteW),
        .o_fwd_a       (w_fwd_a),
        .o_fwd_b       (w_fwd_b)
    );

    // Load-use: the load's data is not available until after memory, so a
    // dependent instruction in decode must wait one cycle.
    assign w_lu = iIsLoadE && iRegWriteE && (iRdE != {REG_ADDR_W{1'b0}}) &&
                  ((iUseRs1D && (iRs1D == iRdE)) || (iUseRs2D && (iRs2D == iRdE)));

    // FSM state, penalty counter and deferred-redirect flag.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next-state and control output decode. Memory wait always wins; a
    // redirect (live or deferred during a wait) beats both penalty flushing
    // and the load-use bubble.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_pend;
        w_stall_f     = 1'b0;
        w_stall_d     = 1'b0;
        w_stall_e     = 1'b0;
        w_stall_m     = 1'b0;
        w_flush_d     = 1'b0;
        w_flush_e     = 1'b0;
        w_pc_redirect = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (iMemBusy) begin
                    w_stall_f   = 1'b1;
                    w_stall_d   = 1'b1;
                    w_stall_e   = 1'b1;
                    w_stall_m   = 1'b1;
                    w_pend_nxt  = r_pend | iRedirectE;
                    w_state_nxt = MEM_WAIT;
                end else if (iRedirectE || r_pend) begin
                    w_pc_redirect = 1'b1;
                    w_flush_d     = 1'b1;
                    w_flush_e     = 1'b1;
                    w_pend_nxt    = 1'b0;
                    w_cnt_nxt     = LP_CNT_RELOAD;
                    w_state_nxt   = (LP_CNT_RELOAD != 2'd0) ? FLUSH : RUN;
                end else begin
                    w_state_nxt = RUN;
                    if (w_lu) begin
                        w_stall_f = 1'b1;
                        w_stall_d = 1'b1;
                        w_flush_e = 1'b1;
                    end else begin
                        w_flush_e = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (iMemBusy) begin
                    // Penalty is frozen while memory holds the pipeline.
                    w_stall_f  = 1'b1;
                    w_stall_d  = 1'b1;
                    w_stall_e  = 1'b1;
                    w_stall_m  = 1'b1;
                    w_pend_nxt = r_pend | iRedirectE;
                end else if (iRedirectE || r_pend) begin
                    w_pc_redirect = 1'b1;
                    w_flush_d     = 1'b1;
                    w_flush_e     = 1'b1;
                    w_pend_nxt    = 1'b0;
                    w_cnt_nxt     = LP_CNT_RELOAD;
                    w_state_nxt   = (LP_CNT_RELOAD != 2'd0) ? FLUSH : RUN;
                end else begin
                    w_flush_d = 1'b1;
                    if (r_cnt > 2'd1) begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end else begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 2'd0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs are forced inactive while reset is asserted, regardless of
    // what the upstream stages are presenting.
    assign oStallF     = w_stall_f & iRstN;
    assign oStallD     = w_stall_d & iRstN;
    assign oStallE     = w_stall_e & iRstN;
    assign oStallM     = w_stall_m & iRstN;
    assign oFlushD     = w_flush_d & iRstN;
    assign oFlushE     = w_flush_e & iRstN;
    assign oPcRedirect = w_pc_redirect & iRstN;
    assign oFwdA       = iRstN ? w_fwd_a : FWD_REG;
    assign oFwdB       = iRstN ? w_fwd_b : FWD_REG;
    assign oState      = r_state;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_W-1:0] LP_PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] LP_PERF_MAX = {PERF_W{1'b1}};

    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_cycles;
    logic [PERF_W-1:0] r_redirects;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val,
                                                   input logic en);
        logic [PERF_W-1:0] res;
        if (en && (val != LP_PERF_MAX)) begin
            res = val + LP_PERF_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Saturating event counters.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_stall_cycles <= {PERF_W{1'b0}};
            r_flush_cycles <= {PERF_W{1'b0}};
            r_redirects    <= {PERF_W{1'b0}};
        end else begin
            r_stall_cycles <= sat_inc(r_stall_cycles, w_stall_f);
            r_flush_cycles <= sat_inc(r_flush_cycles, w_flush_d);
            r_redirects    <= sat_inc(r_redirects, w_pc_redirect);
        end
    end

    assign oStallCycles = r_stall_cycles;
    assign oFlushCycles = r_flush_cycles;
    assign oRedirects   = r_redirects;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: directed scenarios followed by a
// randomized run against a behavioural model of the hazard rules.
// Control vector layout: {StallF, StallD, StallE, StallM, FlushD, FlushE, PcRedirect}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int P = 2;
    localparam int AW = 5;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] rs1_d, rs2_d, rd_e, rs1_e, rs2_e, rd_m, rd_w;
    logic use_rs1_d, use_rs2_d, reg_write_e, is_load_e, reg_write_m, reg_write_w;
    logic redirect_e, mem_busy;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_redirect;
    logic [1:0] fwd_a, fwd_b, state;
    logic [6:0] ctl;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush, perf_redir;
`endif

    int tests = 0;
    int fails = 0;

    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_redirect};

    always #5 clk = ~clk;

    hazard_ctrl #(.REDIRECT_PENALTY(P), .REG_ADDR_W(AW), .PERF_W(32)) dut (
        .iClk(clk), .iRstN(rst_n),
        .iRs1D(rs1_d), .iRs2D(rs2_d), .iUseRs1D(use_rs1_d), .iUseRs2D(use_rs2_d),
        .iRdE(rd_e), .iRegWriteE(reg_write_e), .iIsLoadE(is_load_e),
        .iRs1E(rs1_e), .iRs2E(rs2_e),
        .iRdM(rd_m), .iRegWriteM(reg_write_m),
        .iRdW(rd_w), .iRegWriteW(reg_write_w),
        .iRedirectE(redirect_e), .iMemBusy(mem_busy),
        .oStallF(stall_f), .oStallD(stall_d), .oStallE(stall_e), .oStallM(stall_m),
        .oFlushD(flush_d), .oFlushE(flush_e), .oPcRedirect(pc_redirect),
        .oFwdA(fwd_a), .oFwdB(fwd_b), .oState(state)
`ifdef HAZARD_PERF_CNT_EN
        , .oStallCycles(perf_stall), .oFlushCycles(perf_flush), .oRedirects(perf_redir)
`endif
    );

    task automatic drive_idle();
        rs1_d = 5'd0; rs2_d = 5'd0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
        rd_e = 5'd0; reg_write_e = 1'b0; is_load_e = 1'b0;
        rs1_e = 5'd0; rs2_e = 5'd0; rd_m = 5'd0; reg_write_m = 1'b0;
        rd_w = 5'd0; reg_write_w = 1'b0; redirect_e = 1'b0; mem_busy = 1'b0;
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        mem_busy = 1'b1; redirect_e = 1'b1;
        reg_write_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3;
        @(negedge clk);
        tests++;
        if ({ctl, fwd_a, fwd_b} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b exp 0", {ctl, fwd_a, fwd_b});
        end
        tests++;
        if (state !== S_RUN) begin
            fails++;
            $display("FAIL reset_state got %0d exp %0d", state, S_RUN);
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (ctl !== 7'd0 || state !== S_RUN) begin
            fails++;
            $display("FAIL reset_release got ctl=%b st=%0d exp ctl=0 st=0", ctl, state);
        end
    endtask

    task automatic test_load_use();
        // LOAD x5 in execute, decode reads rs1=x5
        is_load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd5;
        use_rs1_d = 1'b1; rs1_d = 5'd5;
        @(negedge clk);
        tests++;
        if (ctl !== 7'b1100010) begin
            fails++;
            $display("FAIL load_use_bubble got %b exp 1100010", ctl);
        end
        next_cycle();
        is_load_e = 1'b0; reg_write_e = 1'b0;
        @(negedge clk);
        tests++;
        if (ctl !== 7'd0 || state !== S_RUN) begin
            fails++;
            $display("FAIL load_use_after got ctl=%b st=%0d exp 0", ctl, state);
        end
        // x0 destination never hazards; rs2 path also detects
        next_cycle();
        is_load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
        @(negedge clk);
        tests++;
        if (ctl !== 7'd0) begin
            fails++;
            $display("FAIL load_use_x0 got %b exp 0", ctl);
        end
        next_cycle();
        rd_e = 5'd9; use_rs1_d = 1'b0; rs1_d = 5'd9; use_rs2_d = 1'b1; rs2_d = 5'd9;
        @(negedge clk);
        tests++;
        if (ctl !== 7'b1100010) begin
            fails++;
            $display("FAIL load_use_rs2 got %b exp 1100010", ctl);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_fwd_priority();
        reg_write_m = 1'b1; rd_m = 5'd7; reg_write_w = 1'b1; rd_w = 5'd7;
        rs1_e = 5'd7; rs2_e = 5'd3;
        #1;
        tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL fwd_mem_priority got a=%b b=%b exp a=10 b=00", fwd_a, fwd_b);
        end
        rd_m = 5'd0; rs2_e = 5'd7;
        #1;
        tests++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            fails++;
            $display("FAIL fwd_wb got a=%b b=%b exp a=01 b=01", fwd_a, fwd_b);
        end
        rd_m = 5'd3; reg_write_m = 1'b0; rs1_e = 5'd3; rd_w = 5'd0; rs2_e = 5'd0;
        #1;
        tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL fwd_none got a=%b b=%b exp a=00 b=00", fwd_a, fwd_b);
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_redirect();
        logic [6:0] exp_ctl [3] = '{7'b0000111, 7'b0000100, 7'b0000000};
        logic [1:0] exp_st [3] = '{S_RUN, S_FLUSH, S_RUN};
        redirect_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (ctl !== exp_ctl[i] || state !== exp_st[i]) begin
                fails++;
                $display("FAIL redirect_c%0d got ctl=%b st=%0d exp ctl=%b st=%0d",
                         i, ctl, state, exp_ctl[i], exp_st[i]);
            end
            next_cycle();
            redirect_e = 1'b0;
        end
    endtask

    task automatic test_redirect_memwait();
        logic [6:0] exp_ctl [6] = '{7'b1111000, 7'b1111000, 7'b1111000,
                                    7'b0000111, 7'b0000100, 7'b0000000};
        logic [1:0] exp_st [6] = '{S_RUN, S_WAIT, S_WAIT, S_WAIT, S_FLUSH, S_RUN};
        for (int i = 0; i < 6; i++) begin
            mem_busy = (i < 3);
            redirect_e = (i == 0);
            @(negedge clk);
            tests++;
            if (ctl !== exp_ctl[i] || state !== exp_st[i]) begin
                fails++;
                $display("FAIL redirect_memwait_c%0d got ctl=%b st=%0d exp ctl=%b st=%0d",
                         i, ctl, state, exp_ctl[i], exp_st[i]);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_redirect_lu();
        is_load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd12;
        use_rs1_d = 1'b1; rs1_d = 5'd12; redirect_e = 1'b1;
        @(negedge clk);
        tests++;
        if (ctl !== 7'b0000111) begin
            fails++;
            $display("FAIL redirect_beats_lu got %b exp 0000111", ctl);
        end
        next_cycle();
        drive_idle();
        repeat (2) next_cycle();
    endtask

    task automatic test_reset_midflush();
        redirect_e = 1'b1;
        next_cycle();
        redirect_e = 1'b0;
        mem_busy = 1'b1; reg_write_m = 1'b1; rd_m = 5'd4; rs1_e = 5'd4;
        #1;
        tests++;
        if (ctl !== 7'b1111000 || state !== S_FLUSH) begin
            fails++;
            $display("FAIL flush_busy got ctl=%b st=%0d exp ctl=1111000 st=2", ctl, state);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ctl, fwd_a, fwd_b} !== 11'd0 || state !== S_RUN) begin
            fails++;
            $display("FAIL reset_midflush got out=%b st=%0d exp 0", {ctl, fwd_a, fwd_b}, state);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        tests++;
        if (ctl !== 7'd0 || state !== S_RUN) begin
            fails++;
            $display("FAIL reset_midflush_release got ctl=%b st=%0d exp 0", ctl, state);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests++;
        if (perf_stall !== 32'd0 || perf_flush !== 32'd0 || perf_redir !== 32'd0) begin
            fails++;
            $display("FAIL perf_reset got %0d %0d %0d exp 0", perf_stall, perf_flush, perf_redir);
        end
`endif
        next_cycle();
    endtask

    // Behavioural model: mode 0=running, 1=waiting on memory, 2=paying the
    // redirect penalty with 'left' flush cycles still owed after this one.
    task automatic test_random();
        int mode, left;
        bit pend;
        int n_mode, n_left;
        bit n_pend, lu;
        logic [6:0] e_ctl;
        logic [1:0] e_a, e_b;
        int c_stall, c_flush, c_redir;
        do_reset();
        mode = 0; left = 0; pend = 1'b0;
        c_stall = 0; c_flush = 0; c_redir = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
            use_rs1_d = 1'($urandom); use_rs2_d = 1'($urandom);
            rd_e = AW'($urandom_range(0, 3)); reg_write_e = 1'($urandom);
            is_load_e = 1'($urandom);
            rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
            rd_m = AW'($urandom_range(0, 3)); reg_write_m = 1'($urandom);
            rd_w = AW'($urandom_range(0, 3)); reg_write_w = 1'($urandom);
            mem_busy = ($urandom_range(0, 4) == 0);
            redirect_e = ($urandom_range(0, 5) == 0);

            e_a = (reg_write_m && rd_m != 0 && rd_m == rs1_e) ? 2'b10 :
                  (reg_write_w && rd_w != 0 && rd_w == rs1_e) ? 2'b01 : 2'b00;
            e_b = (reg_write_m && rd_m != 0 && rd_m == rs2_e) ? 2'b10 :
                  (reg_write_w && rd_w != 0 && rd_w == rs2_e) ? 2'b01 : 2'b00;
            lu = is_load_e && reg_write_e && rd_e != 0 &&
                 ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
            n_mode = mode; n_left = left; n_pend = pend;
            if (mem_busy) begin
                e_ctl = 7'b1111000;
                n_pend = pend || redirect_e;
                n_mode = (mode == 2) ? 2 : 1;
            end else if (redirect_e || pend) begin
                e_ctl = 7'b0000111;
                n_pend = 1'b0;
                n_left = P - 1;
                n_mode = (P > 1) ? 2 : 0;
            end else if (mode == 2) begin
                e_ctl = 7'b0000100;
                n_left = left - 1;
                n_mode = (left <= 1) ? 0 : 2;
            end else begin
                e_ctl = lu ? 7'b1100010 : 7'b0000000;
                n_mode = 0;
            end

            @(negedge clk);
            tests++;
            if (ctl !== e_ctl || fwd_a !== e_a || fwd_b !== e_b || state !== 2'(mode)) begin
                fails++;
                $display("FAIL random_c%0d got ctl=%b a=%b b=%b st=%0d exp ctl=%b a=%b b=%b st=%0d",
                         cyc, ctl, fwd_a, fwd_b, state, e_ctl, e_a, e_b, mode);
            end
`ifdef HAZARD_PERF_CNT_EN
            tests++;
            if (perf_stall !== 32'(c_stall) || perf_flush !== 32'(c_flush) ||
                perf_redir !== 32'(c_redir)) begin
                fails++;
                $display("FAIL random_perf_c%0d got %0d %0d %0d exp %0d %0d %0d", cyc,
                         perf_stall, perf_flush, perf_redir, c_stall, c_flush, c_redir);
            end
`endif
            c_stall += int'(e_ctl[6]);
            c_flush += int'(e_ctl[2]);
            c_redir += int'(e_ctl[0]);
            next_cycle();
            mode = n_mode; left = n_left; pend = n_pend;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_redirect();
        test_redirect_memwait();
        test_redirect_lu();
        test_reset_midflush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
